ps2_keycode: RTL
================

PS2_KEYCODE -- requirements
Module: ps2_keycode

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, max system clocks between PS/2 falling edges within a frame before abort (1 ms at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on ps2_clk/ps2_data.
REQ-003 Clk  input  1  system clock; all logic on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-low reset; single clock domain.
REQ-005 ps2_clk  input  1  PS/2 device clock, asynchronous, idle high.
REQ-006 ps2_data  input  1  PS/2 device data, asynchronous, idle high.
REQ-007 keycode  output  8  held HID-style movement code consumed by the ball block: 8'h04 A, 8'h07 D, 8'h16 S, 8'h1A W, 8'h00 none.
REQ-008 key_valid  output  1  one-Clk pulse whenever keycode changes value.
REQ-009 frame_err  output  1  one-Clk pulse on parity, start or stop error, or timeout.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops, then detect ps2_clk falling edge as prev=1, cur=0 of synchronized value; data sampled on that edge only.
REQ-011 Frame FSM SHALL have states IDLE, DATA, PARITY, STOP: IDLE->DATA on edge with data=0; IDLE stays on edge with data=1 (no error).
REQ-012 DATA SHALL shift 8 bits LSB first with a 3-bit counter; after the 8th edge ->PARITY.
REQ-013 PARITY SHALL record odd-parity check (8 data bits plus parity bit XOR to 1); next edge ->STOP.
REQ-014 STOP edge SHALL return to IDLE; byte accepted only if stop bit=1 and parity good, else frame_err pulses and byte discarded.
REQ-015 Timeout counter SHALL clear on every falling edge and in IDLE; reaching TIMEOUT_CYCLES in DATA/PARITY/STOP SHALL force IDLE and pulse frame_err in the same cycle.
REQ-016 Byte layer: 8'hF0 SHALL set break_pending; next accepted byte consumed as release and clears break_pending.
REQ-017 Make of mapped code SHALL set keycode: 8'h1D->8'h1A, 8'h1C->8'h04, 8'h1B->8'h16, 8'h23->8'h07; unmapped make codes leave keycode unchanged.
REQ-018 Release SHALL set keycode to 8'h00 only if released code maps to the current keycode; otherwise keycode unchanged.
REQ-019 Typematic repeat of the held key SHALL keep keycode and SHALL NOT pulse key_valid.
REQ-020 New mapped make while another key held SHALL replace keycode (last-pressed wins) and pulse key_valid.
REQ-021 keycode SHALL update and key_valid pulse exactly 1 Clk after the STOP-edge cycle accepting the byte.
REQ-022 A frame error SHALL NOT clear break_pending or extended prefix state.

Reset
REQ-023 While Reset=0 at posedge Clk: FSM=IDLE, bit counter=0, timeout counter=0, break_pending=0, ext_pending=0, keycode=8'h00, key_valid=0, frame_err=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abandon the partial byte without frame_err; first frame after reset decodes normally.

Configuration
REQ-025 With PS2_EXTENDED_EN defined, 8'hE0 SHALL set ext_pending and the following byte maps arrows: 8'h75->8'h1A, 8'h6B->8'h04, 8'h72->8'h16, 8'h74->8'h07 (make and, with F0, release); ext_pending clears after that byte.
REQ-026 Without PS2_EXTENDED_EN, 8'hE0 and the next non-F0 byte SHALL be discarded (arrow keys have no effect); no ext_pending register synthesized.

Structure
REQ-027 Package ps2_pkg SHALL hold frame state enum, scan-code constants (F0, E0, set-2 make codes) and HID keycode constants shared with the ball block.
REQ-028 Bit-level synchronizer, edge detect, frame FSM and timeout SHALL live in sub-module ps2_frame_rx emitting byte plus byte_ok/byte_err pulses; ps2_keycode holds byte layer and mapping.

Verification
REQ-029 Frame 8'h1C (start 0, bits, parity 0, stop 1), 12.5 kHz PS/2 clock -> keycode=8'h04, one key_valid pulse.
REQ-030 Frames 1C, F0, 1C -> keycode 04 then 00, two key_valid pulses total.
REQ-031 Frame 8'h1D with parity bit inverted -> frame_err pulse, keycode stays 00, no key_valid.
REQ-032 Start frame then hold ps2_clk high for 60000 Clk -> frame_err pulse at count 50000, FSM IDLE, next 8'h23 gives keycode 07.
REQ-033 Press 1D, press 1B, release 1D -> keycode 1A, 16, stays 16 (release of non-current key ignored).
REQ-034 With PS2_EXTENDED_EN: E0 75 -> keycode 1A; E0 F0 75 -> 00; without macro same stimulus -> keycode stays 00.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 keyboard front end.
//   Frame receiver state enum, PS/2 set-2 scan-code constants (prefixes and the
//   movement make codes) and the HID-style keycodes consumed by the ball block.
//   map_std/map_ext translate a scan code to a movement keycode (KeyNone if unmapped).
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } frame_state_e;

    // Scan-code prefixes
    localparam logic [7:0] ScBreak  = 8'hF0;
    localparam logic [7:0] ScExtend = 8'hE0;

    // Set-2 make codes (standard block)
    localparam logic [7:0] ScW = 8'h1D;
    localparam logic [7:0] ScA = 8'h1C;
    localparam logic [7:0] ScS = 8'h1B;
    localparam logic [7:0] ScD = 8'h23;

    // Set-2 make codes following the E0 prefix (arrow block)
    localparam logic [7:0] ScUp    = 8'h75;
    localparam logic [7:0] ScLeft  = 8'h6B;
    localparam logic [7:0] ScDown  = 8'h72;
    localparam logic [7:0] ScRight = 8'h74;

    // HID-style keycodes shared with the ball block
    localparam logic [7:0] KeyNone = 8'h00;
    localparam logic [7:0] KeyA    = 8'h04;
    localparam logic [7:0] KeyD    = 8'h07;
    localparam logic [7:0] KeyS    = 8'h16;
    localparam logic [7:0] KeyW    = 8'h1A;

    function automatic logic [7:0] map_std(input logic [7:0] sc);
        case (sc)
            ScW:     return KeyW;
            ScA:     return KeyA;
            ScS:     return KeyS;
            ScD:     return KeyD;
            default: return KeyNone;
        endcase
    endfunction

    function automatic logic [7:0] map_ext(input logic [7:0] sc);
        case (sc)
            ScUp:    return KeyW;
            ScLeft:  return KeyA;
            ScDown:  return KeyS;
            ScRight: return KeyD;
            default: return KeyNone;
        endcase
    endfunction

endpackage

// File: rtl/ps2_keycode_if.sv
// ps2_keycode_if -- PS/2 line inputs and keycode outputs of the keyboard block.
//   ps2_clk, ps2_data : PS/2 device lines (asynchronous, idle high)
//   keycode           : held movement keycode
//   key_valid         : one-cycle pulse when keycode changes
//   frame_err         : one-cycle pulse on a rejected or timed-out frame
// Modports: master = keyboard side / consumer, slave = ps2_keycode.
interface ps2_keycode_if;
    import ps2_pkg::*;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keycode,
        input  key_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keycode,
        output key_valid,
        output frame_err
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx -- bit-level PS/2 receiver.
//   Synchronizes ps2_clk/ps2_data, detects ps2_clk falling edges and runs the
//   11-bit frame FSM (start, 8 data LSB first, odd parity, stop) with an
//   inter-edge timeout.
// Ports:
//   Clk, Reset        : system clock, synchronous active-low reset
//   ps2_clk, ps2_data : raw PS/2 lines
//   rx_byte           : last accepted byte (valid with byte_ok)
//   byte_ok           : one-cycle pulse, good frame received
//   byte_err          : one-cycle pulse, parity/stop error or timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       byte_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    frame_state_e           state_q;
    logic [2:0]             bit_cnt_q;
    logic [TW-1:0]          timeout_q;
    logic [7:0]             shift_q;
    logic                   parity_ok_q;
    logic [7:0]             rx_byte_q;
    logic                   byte_ok_q;
    logic                   byte_err_q;

    logic clk_s;
    logic din;
    logic fall;
    logic expired;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign din     = data_sync_q[SYNC_STAGES-1];
    assign fall    = clk_prev_q & ~clk_s;
    // Counter would reach TIMEOUT_CYCLES this cycle with no edge in sight
    assign expired = (state_q != StIdle) && !fall && (timeout_q == TimeoutLast);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            timeout_q   <= '0;
            shift_q     <= '0;
            parity_ok_q <= 1'b0;
            rx_byte_q   <= '0;
            byte_ok_q   <= 1'b0;
            byte_err_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_s;
            byte_ok_q   <= 1'b0;
            byte_err_q  <= 1'b0;

            if (state_q == StIdle || fall) begin
                timeout_q <= '0;
            end else begin
                timeout_q <= timeout_q + 1'b1;
            end

            if (expired) begin
                state_q    <= StIdle;
                timeout_q  <= '0;
                byte_err_q <= 1'b1;
            end else if (fall) begin
                unique case (state_q)
                    StIdle: begin
                        // A high "start" bit is line noise, not an error
                        if (!din) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q   <= {din, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        parity_ok_q <= ^{shift_q, din};
                        state_q     <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (din && parity_ok_q) begin
                            rx_byte_q <= shift_q;
                            byte_ok_q <= 1'b1;
                        end else begin
                            byte_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rx_byte  = rx_byte_q;
    assign byte_ok  = byte_ok_q;
    assign byte_err = byte_err_q;

endmodule

// File: rtl/ps2_keycode.sv
// ps2_keycode -- PS/2 keyboard to movement keycode translator.
//   Receives frames through ps2_frame_rx, tracks the F0 break prefix and maps
//   W/A/S/D make/break codes to a held HID-style keycode (last pressed wins).
// Ports:
//   Clk, Reset : system clock, synchronous active-low reset
//   bus        : ps2_keycode_if.slave (ps2_clk, ps2_data in; keycode,
//                key_valid, frame_err out)
// Build option: PS2_EXTENDED_EN -- when defined, E0-prefixed arrow keys map to
//   the same keycodes as W/A/S/D. When undefined, E0 is dropped and the arrow
//   codes that follow fall outside the standard map, so they have no effect.
module ps2_keycode
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    ps2_keycode_if.slave  bus
);

    logic [7:0] rx_byte;
    logic       byte_ok;
    logic       byte_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame_rx (
        .Clk      (Clk),
        .Reset    (Reset),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .rx_byte  (rx_byte),
        .byte_ok  (byte_ok),
        .byte_err (byte_err)
    );

    logic [7:0] keycode_q, keycode_d;
    logic       break_q, break_d;
    logic       key_valid_q;
    logic [7:0] mapped;
`ifdef PS2_EXTENDED_EN
    logic       ext_q, ext_d;
`endif

    // Only accepted bytes touch prefix state, so a frame error leaves it intact
    always_comb begin
        keycode_d = keycode_q;
        break_d   = break_q;
        mapped    = KeyNone;
`ifdef PS2_EXTENDED_EN
        ext_d     = ext_q;
`endif
        if (byte_ok) begin
            if (rx_byte == ScBreak) begin
                break_d = 1'b1;
            end else if (rx_byte == ScExtend) begin
`ifdef PS2_EXTENDED_EN
                ext_d = 1'b1;
`endif
            end else begin
`ifdef PS2_EXTENDED_EN
                mapped = ext_q ? map_ext(rx_byte) : map_std(rx_byte);
                ext_d  = 1'b0;
`else
                mapped = map_std(rx_byte);
`endif
                if (break_q) begin
                    break_d = 1'b0;
                    // Releasing a key other than the held one changes nothing
                    if (mapped != KeyNone && mapped == keycode_q) begin
                        keycode_d = KeyNone;
                    end
                end else if (mapped != KeyNone) begin
                    keycode_d = mapped;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            keycode_q   <= KeyNone;
            break_q     <= 1'b0;
            key_valid_q <= 1'b0;
`ifdef PS2_EXTENDED_EN
            ext_q       <= 1'b0;
`endif
        end else begin
            keycode_q   <= keycode_d;
            break_q     <= break_d;
            // Typematic repeats leave keycode_d == keycode_q, so no pulse
            key_valid_q <= (keycode_d != keycode_q);
`ifdef PS2_EXTENDED_EN
            ext_q       <= ext_d;
`endif
        end
    end

    assign bus.keycode   = keycode_q;
    assign bus.key_valid = key_valid_q;
    // Registered pulse from the receiver, same cycle its FSM returns to idle
    assign bus.frame_err = byte_err;

endmodule
